// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port block RAM between the fetch port and the data port.
// Data has priority; fetch is forced through after STARVE_LIMIT consecutive denials.
module mem_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [15:0]       if_addr,
    output logic [15:0]       if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [15:0]       d_addr,
    input  logic [15:0]       d_wdata,
    output logic [15:0]       d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    output logic [15:0]       if_grant_cnt,
    output logic [15:0]       d_grant_cnt
);

    typedef enum logic [1:0] {
        LG_NONE = 2'd0,
        LG_IF   = 2'd1,
        LG_DRD  = 2'd2,
        LG_DWR  = 2'd3
    } grant_e;

    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    grant_e      last_q, last_d;
    logic [3:0]  starve_q, starve_d;
    logic [15:0] if_hold_q, if_hold_d;
    logic [15:0] d_hold_q, d_hold_d;
    logic [15:0] if_cnt_q, if_cnt_d;
    logic [15:0] d_cnt_q, d_cnt_d;

    logic d_req;
    logic data_first;
    logic fetch_grant;
    logic data_grant;

    always_comb begin
        d_req       = d_read | d_write;
        data_first  = d_req && (starve_q < LIMIT);
        fetch_grant = ~reset & if_req & ~data_first;
        data_grant  = ~reset & d_req & (data_first | ~if_req);

        ram_en    = fetch_grant | data_grant;
        ram_we    = data_grant & d_write;
        ram_addr  = fetch_grant ? if_addr[ADDR_W:1] : d_addr[ADDR_W:1];
        ram_wdata = d_wdata;

        if_stall = ~reset & if_req & ~fetch_grant;
        d_stall  = ~reset & d_req & ~data_grant;

        // Responses are driven straight from the RAM output; an in-flight one is dropped under reset.
        if_valid = ~reset & (last_q == LG_IF);
        d_valid  = ~reset & ((last_q == LG_DRD) || (last_q == LG_DWR));
        if_rdata = if_valid ? ram_rdata : if_hold_q;
        d_rdata  = (~reset && last_q == LG_DRD) ? ram_rdata : d_hold_q;

        if_grant_cnt = if_cnt_q;
        d_grant_cnt  = d_cnt_q;

        last_d = LG_NONE;
        if (fetch_grant)
            last_d = LG_IF;
        else if (data_grant)
            last_d = d_write ? LG_DWR : LG_DRD;

        starve_d = starve_q;
        if (fetch_grant || !if_req)
            starve_d = '0;
        else if (starve_q < LIMIT)
            starve_d = starve_q + 4'd1;

        if_hold_d = if_rdata;
        d_hold_d  = d_rdata;
        if_cnt_d  = if_cnt_q + {15'd0, fetch_grant};
        d_cnt_d   = d_cnt_q + {15'd0, data_grant};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_q    <= LG_NONE;
            starve_q  <= '0;
            if_hold_q <= '0;
            d_hold_q  <= '0;
            if_cnt_q  <= '0;
            d_cnt_q   <= '0;
        end else begin
            last_q    <= last_d;
            starve_q  <= starve_d;
            if_hold_q <= if_hold_d;
            d_hold_q  <= d_hold_d;
            if_cnt_q  <= if_cnt_d;
            d_cnt_q   <= d_cnt_d;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous block RAM between the pipeline's instruction fetch port and its data (MEM-stage) port.
- Grants one access per cycle, with data priority and bounded fetch starvation.
- Returns read data with one-cycle latency.
- Drives per-port stall signals that feed the PC hold and pipeline-freeze logic.

Parameters:
- ADDR_W, 10, RAM word-address width (1024 x 16-bit words).
- STARVE_LIMIT, 3, consecutive denied fetch cycles after which fetch wins over data; legal range 1..15.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- if_req  input  1  fetch request (read only)
- if_addr  input  16  fetch byte address
- if_rdata  output  16  fetch read data
- if_valid  output  1  if_rdata valid this cycle
- if_stall  output  1  fetch request not granted this cycle
- d_read  input  1  data read request
- d_write  input  1  data write request
- d_addr  input  16  data byte address
- d_wdata  input  16  data write data
- d_rdata  output  16  data read data
- d_valid  output  1  data read data valid, or write acknowledged
- d_stall  output  1  data request not granted this cycle
- ram_en  output  1  RAM enable
- ram_we  output  1  RAM write enable
- ram_addr  output  ADDR_W  RAM word address
- ram_wdata  output  16  RAM write data
- ram_rdata  input  16  RAM read data, valid the cycle after a read enable
- if_grant_cnt  output  16  count of fetch grants
- d_grant_cnt  output  16  count of data grants

Behaviour:
- Reset is synchronous and active-high, on clock; reset is `reset`, clock is `clock`.
- Reset values: if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, both counters=0, starve_cnt=0, last_grant=NONE.
- During reset, ram_en=0 and both stall outputs are 0.
- d_req = d_read | d_write. When both are set, the access is a write and the read is ignored.
- Arbitration is combinational in the request cycle:
  - Data wins if d_req is set and starve_cnt < STARVE_LIMIT.
  - Otherwise fetch wins if if_req is set.
  - Otherwise data wins if d_req is set.
  - Otherwise there is no grant.
- Grant drive:
  - ram_en=1 for any grant.
  - ram_we=1 only for a data write.
  - ram_addr = winner_addr[ADDR_W:1]; bit 0 is ignored (word aligned).
  - ram_wdata = d_wdata.
- Stall outputs: if_stall = if_req & ~fetch_grant; d_stall = d_req & ~data_grant. An idle port never stalls.
- Requester contract: hold request, address and write data stable while stalled. The arbiter does not queue requests.
- last_grant register (NONE, IF, DRD, DWR) is loaded every cycle with that cycle's grant.
- Response timing, one cycle after the grant:
  - last_grant=IF: if_valid=1 and if_rdata=ram_rdata.
  - last_grant=DRD: d_valid=1 and d_rdata=ram_rdata.
  - last_grant=DWR: d_valid=1 and d_rdata is unchanged.
  - Otherwise both valids are 0.
- Hold: if_rdata and d_rdata keep their last valid value, via holding registers loaded in the valid cycle, until the next valid for that port.
- Back-to-back grants to the same port give one response per cycle; throughput is 1 access per cycle.
- starve_cnt:
  - Increments when if_req & ~fetch_grant, saturating at STARVE_LIMIT.
  - Clears to 0 on a fetch grant or when if_req=0.
- Counters: if_grant_cnt and d_grant_cnt increment by 1 per grant of their port and wrap 0xFFFF->0.
- Reset mid-operation: the in-flight response is dropped (no valid after reset) and starve_cnt is cleared. An outstanding RAM write issued before the reset edge is not undone.

Test Plan:
1. Preload RAM[5]=0x1234. Fetch only, if_addr=0x000A, single cycle → ram_addr=5, ram_we=0, if_stall=0. Next cycle if_valid=1, if_rdata=0x1234; if_rdata holds 0x1234 after if_req drops.
2. Data write d_addr=0x0010, d_wdata=0xBEEF, then read the same address → cycle 0: ram_we=1, ram_addr=8. Cycle 1: d_valid=1 (ack), read granted. Cycle 2: d_valid=1, d_rdata=0xBEEF.
3. Contention, fetch and data read asserted together with STARVE_LIMIT=3 → data wins 3 cycles with if_stall=1. Cycle 4: fetch wins and d_stall=1. Cycle 5: data resumes. if_grant_cnt=1, d_grant_cnt=4 after 5 cycles.
4. d_read=d_write=1 → treated as a write: ram_we=1, d_valid=1 next cycle, d_rdata unchanged.
5. Grant IF, then assert reset on the next edge → if_valid=0 after reset, counters=0, stalls=0, starve_cnt=0.
6. Counter wrap, forcing if_grant_cnt=0xFFFF and then granting fetch once → if_grant_cnt=0x0000.
